// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
//   Bundle of pipeline-control signals between the datapath stages and the
//   pipeline control unit (pipe_ctrl).
//
//   Parameters:
//     ADDR_W            width of the program counter and redirect target
//
//   Signals (stage -> controller):
//     JumpFlagIn        execute stage requests a redirect
//     JumpAddrIn        redirect target from execute stage
//     HaltIn            execute stage holds ebreak
//     LoadUseHoldIn     decode stage detects a load-use dependency
//     MemBusyIn         memory stage cannot complete this cycle
//     InstReadyIn       fetch returns the instruction for PcOut this cycle
//   Signals (controller -> stages):
//     PcOut             current fetch address (registered)
//     InstReqValidOut   fetch request valid for PcOut
//     StallIfIdOut      hold IF/ID register
//     FlushIfIdOut      load bubble into IF/ID
//     StallIdExOut      hold ID/EX register
//     FlushIdExOut      load bubble into ID/EX
//     StallExMemOut     hold EX/MEM register
//     HaltedOut         core halted (registered, sticky)
//     CtrlStateOut      controller FSM state, debug only
//
//   Modports:
//     master            pipeline stages (drive requests, consume controls)
//     slave             pipeline control unit
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              JumpFlagIn;
    logic [ADDR_W-1:0] JumpAddrIn;
    logic              HaltIn;
    logic              LoadUseHoldIn;
    logic              MemBusyIn;
    logic              InstReadyIn;

    logic [ADDR_W-1:0] PcOut;
    logic              InstReqValidOut;
    logic              StallIfIdOut;
    logic              FlushIfIdOut;
    logic              StallIdExOut;
    logic              FlushIdExOut;
    logic              StallExMemOut;
    logic              HaltedOut;
    logic [1:0]        CtrlStateOut;

    modport master (
        output JumpFlagIn,
        output JumpAddrIn,
        output HaltIn,
        output LoadUseHoldIn,
        output MemBusyIn,
        output InstReadyIn,
        input  PcOut,
        input  InstReqValidOut,
        input  StallIfIdOut,
        input  FlushIfIdOut,
        input  StallIdExOut,
        input  FlushIdExOut,
        input  StallExMemOut,
        input  HaltedOut,
        input  CtrlStateOut
    );

    modport slave (
        input  JumpFlagIn,
        input  JumpAddrIn,
        input  HaltIn,
        input  LoadUseHoldIn,
        input  MemBusyIn,
        input  InstReadyIn,
        output PcOut,
        output InstReqValidOut,
        output StallIfIdOut,
        output FlushIfIdOut,
        output StallIdExOut,
        output FlushIdExOut,
        output StallExMemOut,
        output HaltedOut,
        output CtrlStateOut
    );
endinterface : pipe_ctrl_if

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline control unit for the five-stage RV64I core. Owns the program
//   counter and the instruction-fetch request, arbitrates halt / memory-busy /
//   redirect / load-use / fetch-miss events and drives the per-stage stall and
//   flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
//
//   Parameters:
//     RESET_PC   PC value loaded on reset
//     ADDR_W     width of PC and redirect target
//
//   Ports:
//     Clk        core clock, all state updates on rising edge
//     Rst        synchronous active-low reset
//     bus        pipe_ctrl_if.slave (requests in, PC / stall / flush out)
//
//   PcOut, the FSM state and HaltedOut are registered. Stall, flush and
//   InstReqValidOut are combinational from state and inputs so the stages see
//   them in the same cycle as the event that causes them.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000000080000000,
    parameter int          ADDR_W   = 64
) (
    input  logic          Clk,
    input  logic          Rst,
    pipe_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};

    // Force bit 0 of a redirect target low; bit 1 is deliberately left alone.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        align_pc = addr & {{(ADDR_W-1){1'b1}}, 1'b0};
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic              halted_r;

    logic              inst_req_s;
    logic              stall_if_id_s;
    logic              flush_if_id_s;
    logic              stall_id_ex_s;
    logic              flush_id_ex_s;
    logic              stall_ex_mem_s;

    // State, PC and halted flag registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_PC_W;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            // Sticky: the only way out of HALT is reset.
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

    // Next-state, next-PC and per-stage control decode.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        inst_req_s     = 1'b0;
        stall_if_id_s  = 1'b0;
        flush_if_id_s  = 1'b0;
        stall_id_ex_s  = 1'b0;
        flush_id_ex_s  = 1'b0;
        stall_ex_mem_s = 1'b0;

        case (state_r)
            ST_BOOT: begin
                // Pipeline registers hold garbage after reset: bubble them.
                flush_if_id_s = 1'b1;
                flush_id_ex_s = 1'b1;
                state_nxt_s   = ST_RUN;
            end

            ST_RUN: begin
                inst_req_s = 1'b1;
                if (bus.HaltIn) begin
                    stall_if_id_s  = 1'b1;
                    stall_id_ex_s  = 1'b1;
                    stall_ex_mem_s = 1'b1;
                    state_nxt_s    = ST_HALT;
                end else if (bus.MemBusyIn) begin
                    // Execute is frozen and will re-present any jump, so a
                    // coincident JumpFlagIn is intentionally dropped here.
                    stall_if_id_s  = 1'b1;
                    stall_id_ex_s  = 1'b1;
                    stall_ex_mem_s = 1'b1;
                end else if (bus.JumpFlagIn) begin
                    // Kill the two younger instructions; load-use on the
                    // flushed instruction no longer matters.
                    flush_if_id_s = 1'b1;
                    flush_id_ex_s = 1'b1;
                    pc_nxt_s      = align_pc(bus.JumpAddrIn);
                    if (!bus.InstReadyIn) begin
                        // Fetch for the old PC is still outstanding; its
                        // response must be dropped when it arrives.
                        state_nxt_s = ST_DISCARD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (bus.LoadUseHoldIn) begin
                    stall_if_id_s = 1'b1;
                    flush_id_ex_s = 1'b1;
                end else if (!bus.InstReadyIn) begin
                    flush_if_id_s = 1'b1;
                end else begin
                    pc_nxt_s = pc_r + PC_STEP;
                end
            end

            ST_DISCARD: begin
                // No new fetch while the stale response is outstanding; PC
                // already holds the redirect target. JumpFlagIn is ignored
                // because execute holds a flushed bubble.
                flush_if_id_s = 1'b1;
                if (bus.MemBusyIn) begin
                    stall_id_ex_s  = 1'b1;
                    stall_ex_mem_s = 1'b1;
                end else begin
                    stall_id_ex_s  = 1'b0;
                    stall_ex_mem_s = 1'b0;
                end
                if (bus.HaltIn) begin
                    state_nxt_s = ST_HALT;
                end else if (bus.InstReadyIn) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end

            ST_HALT: begin
                stall_if_id_s  = 1'b1;
                stall_id_ex_s  = 1'b1;
                stall_ex_mem_s = 1'b1;
                state_nxt_s    = ST_HALT;
            end

            default: begin
                // Unreachable encoding: recover through BOOT with bubbles.
                flush_if_id_s = 1'b1;
                flush_id_ex_s = 1'b1;
                state_nxt_s   = ST_BOOT;
            end
        endcase
    end

    assign bus.PcOut           = pc_r;
    assign bus.HaltedOut       = halted_r;
    assign bus.CtrlStateOut    = state_r;
    assign bus.InstReqValidOut = inst_req_s;
    assign bus.StallIfIdOut    = stall_if_id_s;
    assign bus.FlushIfIdOut    = flush_if_id_s;
    assign bus.StallIdExOut    = stall_id_ex_s;
    assign bus.FlushIdExOut    = flush_id_ex_s;
    assign bus.StallExMemOut   = stall_ex_mem_s;

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Self-checking bench for pipe_ctrl. Each scenario task queues per-cycle
//   stimulus together with the expected outputs for that cycle, then plays the
//   queue: inputs change on the falling edge, outputs are compared 1 time unit
//   later. Observed vector layout:
//     {PcOut, CtrlStateOut, HaltedOut, InstReqValidOut,
//      StallIfId, FlushIfId, StallIdEx, FlushIdEx, StallExMem}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int ADDR_W = 64;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DISC = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    // {sif, fif, sie, fie, sem}
    localparam logic [4:0] F_NONE  = 5'b00000;
    localparam logic [4:0] F_STALL = 5'b10101;
    localparam logic [4:0] F_FLUSH = 5'b01010;
    localparam logic [4:0] F_LU    = 5'b10010;
    localparam logic [4:0] F_FIF   = 5'b01000;
    localparam logic [4:0] F_DBUSY = 5'b01101;

    typedef struct {
        logic              rst;
        logic              jf;
        logic [ADDR_W-1:0] ja;
        logic              halt;
        logic              lu;
        logic              mb;
        logic              rdy;
    } stim_t;

    typedef struct {
        string       name;
        logic [72:0] v;
    } exp_t;

    logic  clk;
    logic  rst;
    stim_t sq[$];
    exp_t  exp_q[$];
    int    checks;
    int    failures;

    pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    pipe_ctrl #(
        .RESET_PC (64'h0000000080000000),
        .ADDR_W   (ADDR_W)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t s(input logic r, input logic jf, input logic [63:0] ja,
                                input logic h, input logic lu, input logic mb, input logic rdy);
        stim_t t;
        t.rst = r; t.jf = jf; t.ja = ja; t.halt = h; t.lu = lu; t.mb = mb; t.rdy = rdy;
        return t;
    endfunction

    function automatic exp_t e(input string n, input logic [63:0] pc, input logic [1:0] st,
                               input logic h, input logic req, input logic [4:0] f);
        exp_t x;
        x.name = n;
        x.v    = {pc, st, h, req, f};
        return x;
    endfunction

    function automatic logic [72:0] observed();
        return {bus.PcOut, bus.CtrlStateOut, bus.HaltedOut, bus.InstReqValidOut,
                bus.StallIfIdOut, bus.FlushIfIdOut, bus.StallIdExOut,
                bus.FlushIdExOut, bus.StallExMemOut};
    endfunction

    task automatic apply(input stim_t t);
        @(negedge clk);
        rst               = t.rst;
        bus.JumpFlagIn    = t.jf;
        bus.JumpAddrIn    = t.ja;
        bus.HaltIn        = t.halt;
        bus.LoadUseHoldIn = t.lu;
        bus.MemBusyIn     = t.mb;
        bus.InstReadyIn   = t.rdy;
    endtask

    // Push one cycle of stimulus and its expected outputs.
    task automatic push(input stim_t t, input exp_t x);
        sq.push_back(t);
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        exp_t x;
        push(s(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1), e("rst_boot", 64'h80000000, S_BOOT, 1'b0, 1'b0, F_FLUSH));
        push(s(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1), e("run_pc0",  64'h80000000, S_RUN,  1'b0, 1'b1, F_NONE));
        push(s(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1), e("run_pc4",  64'h80000004, S_RUN,  1'b0, 1'b1, F_NONE));
        push(s(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1), e("run_pc8",  64'h80000008, S_RUN,  1'b0, 1'b1, F_NONE));
        push(s(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1), e("run_pcc",  64'h8000000C, S_RUN,  1'b0, 1'b1, F_NONE));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            #1;
            x = exp_q.pop_front();
            checks++;
            if (observed() !== x.v) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", x.name, observed(), x.v);
            end
        end
    endtask

    task automatic test_jump_ready();
        exp_t x;
        push(s(1'b1, 1'b1, 64'h80000101, 1'b0, 1'b0, 1'b0, 1'b1), e("jmp_rdy_flush", 64'h80000010, S_RUN, 1'b0, 1'b1, F_FLUSH));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("jmp_rdy_tgt",   64'h80000100, S_RUN, 1'b0, 1'b1, F_NONE));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            #1;
            x = exp_q.pop_front();
            checks++;
            if (observed() !== x.v) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", x.name, observed(), x.v);
            end
        end
    endtask

    task automatic test_jump_discard();
        exp_t x;
        push(s(1'b1, 1'b1, 64'h80000101, 1'b0, 1'b0, 1'b0, 1'b0), e("jmp_miss_flush", 64'h80000104, S_RUN,  1'b0, 1'b1, F_FLUSH));
        push(s(1'b1, 1'b1, 64'h80000500, 1'b0, 1'b0, 1'b0, 1'b0), e("disc_1",         64'h80000100, S_DISC, 1'b0, 1'b0, F_FIF));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b1, 1'b0), e("disc_2_busy",    64'h80000100, S_DISC, 1'b0, 1'b0, F_DBUSY));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b0), e("disc_3",         64'h80000100, S_DISC, 1'b0, 1'b0, F_FIF));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("disc_drop",      64'h80000100, S_DISC, 1'b0, 1'b0, F_FIF));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("disc_back_run",  64'h80000100, S_RUN,  1'b0, 1'b1, F_NONE));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("disc_inc",       64'h80000104, S_RUN,  1'b0, 1'b1, F_NONE));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            #1;
            x = exp_q.pop_front();
            checks++;
            if (observed() !== x.v) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", x.name, observed(), x.v);
            end
        end
    endtask

    task automatic test_membusy_jump();
        exp_t x;
        push(s(1'b1, 1'b1, 64'h80000200, 1'b0, 1'b0, 1'b1, 1'b1), e("busy_jmp_1", 64'h80000108, S_RUN, 1'b0, 1'b1, F_STALL));
        push(s(1'b1, 1'b1, 64'h80000200, 1'b0, 1'b0, 1'b1, 1'b1), e("busy_jmp_2", 64'h80000108, S_RUN, 1'b0, 1'b1, F_STALL));
        push(s(1'b1, 1'b1, 64'h80000200, 1'b0, 1'b0, 1'b0, 1'b1), e("busy_jmp_3", 64'h80000108, S_RUN, 1'b0, 1'b1, F_FLUSH));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("busy_tgt",   64'h80000200, S_RUN, 1'b0, 1'b1, F_NONE));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            #1;
            x = exp_q.pop_front();
            checks++;
            if (observed() !== x.v) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", x.name, observed(), x.v);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t x;
        push(s(1'b1, 1'b1, 64'h80000020, 1'b0, 1'b0, 1'b0, 1'b1), e("lu_jmp",      64'h80000204, S_RUN, 1'b0, 1'b1, F_FLUSH));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b1, 1'b0, 1'b1), e("lu_hold",     64'h80000020, S_RUN, 1'b0, 1'b1, F_LU));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("lu_release",  64'h80000020, S_RUN, 1'b0, 1'b1, F_NONE));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b0), e("lu_adv_miss", 64'h80000024, S_RUN, 1'b0, 1'b1, F_FIF));
        push(s(1'b1, 1'b1, 64'h80000040, 1'b0, 1'b1, 1'b0, 1'b1), e("lu_vs_jmp",   64'h80000024, S_RUN, 1'b0, 1'b1, F_FLUSH));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("lu_jmp_tgt",  64'h80000040, S_RUN, 1'b0, 1'b1, F_NONE));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            #1;
            x = exp_q.pop_front();
            checks++;
            if (observed() !== x.v) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", x.name, observed(), x.v);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t x;
        push(s(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFD, 1'b0, 1'b0, 1'b0, 1'b1), e("wrap_jmp",  64'h80000044, S_RUN, 1'b0, 1'b1, F_FLUSH));
        push(s(1'b1, 1'b0, 64'h0,                1'b0, 1'b0, 1'b0, 1'b1), e("wrap_top",  64'hFFFFFFFFFFFFFFFC, S_RUN, 1'b0, 1'b1, F_NONE));
        push(s(1'b1, 1'b0, 64'h0,                1'b0, 1'b0, 1'b0, 1'b1), e("wrap_zero", 64'h0000000000000000, S_RUN, 1'b0, 1'b1, F_NONE));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            #1;
            x = exp_q.pop_front();
            checks++;
            if (observed() !== x.v) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", x.name, observed(), x.v);
            end
        end
    endtask

    task automatic test_halt();
        exp_t x;
        push(s(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1), e("halt_req", 64'h4, S_RUN, 1'b0, 1'b1, F_STALL));
        for (int i = 0; i < 10; i++) begin
            push(s(1'b1, 1'b1, 64'h80000300 + 64'(i * 16), 1'b0, 1'b0, 1'b0, 1'(i % 2)),
                 e("halt_frozen", 64'h4, S_HALT, 1'b1, 1'b0, F_STALL));
        end
        push(s(1'b0, 1'b1, 64'h80000300, 1'b0, 1'b0, 1'b0, 1'b1), e("halt_rst_edge", 64'h4, S_HALT, 1'b1, 1'b0, F_STALL));
        push(s(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1), e("halt_rst_boot", 64'h80000000, S_BOOT, 1'b0, 1'b0, F_FLUSH));
        // Halt raised while a redirect is still discarding.
        push(s(1'b1, 1'b1, 64'h80000600, 1'b0, 1'b0, 1'b0, 1'b0), e("dh_jmp",    64'h80000000, S_RUN,  1'b0, 1'b1, F_FLUSH));
        push(s(1'b1, 1'b0, 64'h0,        1'b1, 1'b0, 1'b0, 1'b0), e("dh_disc",   64'h80000600, S_DISC, 1'b0, 1'b0, F_FIF));
        push(s(1'b0, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("dh_halted", 64'h80000600, S_HALT, 1'b1, 1'b0, F_STALL));
        push(s(1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 1'b0, 1'b1), e("dh_boot",   64'h80000000, S_BOOT, 1'b0, 1'b0, F_FLUSH));
        while (sq.size() > 0) begin
            apply(sq.pop_front());
            #1;
            x = exp_q.pop_front();
            checks++;
            if (observed() !== x.v) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", x.name, observed(), x.v);
            end
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b0;
        bus.JumpFlagIn    = 1'b0;
        bus.JumpAddrIn    = 64'h0;
        bus.HaltIn        = 1'b0;
        bus.LoadUseHoldIn = 1'b0;
        bus.MemBusyIn     = 1'b0;
        bus.InstReadyIn   = 1'b0;
        repeat (2) @(posedge clk);

        test_reset();
        test_jump_ready();
        test_jump_discard();
        test_membusy_jump();
        test_load_use();
        test_wrap();
        test_halt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_ctrl
